cmul_pipe: RTL and testbench
============================

Name: cmul_pipe

Overview:
- Parametrised, pipelined complex multiplier for the radix-2² SDF FFT twiddle stage: out = a × b, or a × conj(b) when the conj input is set.
- Independent data, twiddle and output widths; selectable round/truncate; output saturation.
- Valid/ready handshake with full-pipeline stall, so it sits between SDF butterfly stages and any downstream FIFO without losing samples.

Parameters:
- DW, 16, width of data operand a (signed, two's complement).
- TW, 16, width of twiddle operand b (signed Q1.(TW-1)).
- OW, 16, width of output components (signed).
- ROUND, 1, 1 = round half-up before scaling; 0 = truncate (arithmetic shift).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- conj  in  1  1 = use conj(b); sampled with operands.
- a_re, a_im  in  DW each  data operand.
- b_re, b_im  in  TW each  twiddle operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_re, out_im  out  OW each  result.

Behaviour:
- Reset (async assert, sync release): all valid bits, out_valid, out_re and out_im are 0. Data registers other than outputs need no reset.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational.
- Transfer: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
- Pipeline, three stages, all gated by adv:
  - S1 registers operands and conj. If conj = 1, b_im is negated here in TW+1 bits, so -(-2^(TW-1)) is exact.
  - S2 forms four full-precision products (DW+TW+1 bits): pr = a_re·b_re, pi = a_im·b_im, qr = a_re·b_im, qi = a_im·b_re.
  - S3 forms re = pr - pi and im = qr + qi in DW+TW+2 bits. If ROUND, adds 2^(TW-2). Arithmetic-shifts right by TW-1, then saturates to OW: clip to [-2^(OW-1), 2^(OW-1)-1].
- Latency: exactly 3 cycles from acceptance to out_valid when unstalled. Throughput is 1 per cycle.
- Stall: while out_valid & !out_ready, every stage holds and out_re, out_im and out_valid stay stable. No sample is dropped or duplicated, and order is preserved.
- Bubbles: valid bits propagate with data. Invalid stages still advance when adv = 1. Bubbles are not collapsed beyond what adv allows.
- Simultaneous in/out transfer in the same cycle is legal and sustains full rate.
- Reset mid-stream: in-flight samples are discarded and out_valid drops to 0 immediately on rst_n low.
- in_valid = 0 with in_ready = 1 loads a bubble. Operand values are don't-care.

Optional Feature:
- Macro CMUL_SAT_FLAG_EN.
- Defined: adds out_sat (out, 1) and sat_cnt (out, 16).
  - out_sat = 1 when either component clipped in S3; aligned with out_valid and held during stall.
  - sat_cnt increments once per consumed saturated result, sticks at 16'hFFFF, and resets to 0.
- Undefined: neither port exists, and no saturation-detect logic beyond the clip itself.

Decomposition:
- Package cmul_pkg: width helper functions (product width DW+TW+1, sum width DW+TW+2), the rounding-constant function, and the OW saturation bounds as constants.
- One sub-module, cmul_round_sat: combinational round, shift and saturate of one component. Outputs the clipped value and a sat flag. Instantiated twice in S3.

Test Plan (DW=TW=OW=16, ROUND=1 unless stated):
- a=(16384,0), b=(16384,0), conj=0 -> out=(8192,0) exactly 3 cycles after acceptance.
- a=(0,16384), b=(0,16384): conj=0 -> (-8192,0); conj=1 -> (8192,0).
- a=(-32768,0), b=(-32768,0) -> (32767,0); with CMUL_SAT_FLAG_EN, out_sat=1 and sat_cnt goes 0->1.
- a=(1,0), b=(16384,0): ROUND=1 -> (1,0); ROUND=0 -> (0,0).
- Stream 8 samples with out_ready=0 for 5 cycles after the first output:
  - out data stable and in_ready=0 during the stall.
  - all 8 results delivered in order, none lost or duplicated.
- Pull rst_n low with 3 samples in flight -> out_valid=0 same cycle, outputs 0; after release, the first new input appears 3 cycles later.

Source files
------------

// File: rtl/cmul_pkg.sv
// cmul_pkg: width, rounding and saturation-bound helpers for cmul_pipe
package cmul_pkg;

    function automatic int prod_w(input int dw, input int tw);
        return dw + tw + 1;
    endfunction

    function automatic int sum_w(input int dw, input int tw);
        return dw + tw + 2;
    endfunction

    function automatic longint rnd_const(input int tw);
        return longint'(1) <<< (tw - 2);
    endfunction

    function automatic longint sat_hi(input int ow);
        return (longint'(1) <<< (ow - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

endpackage

// File: rtl/cmul_if.sv
// cmul_if: operand/result handshake bundle; out_sat and sat_cnt exist only with CMUL_SAT_FLAG_EN
interface cmul_if #(
    parameter int DW = 16,
    parameter int TW = 16,
    parameter int OW = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 conj;
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic signed [TW-1:0] b_re;
    logic signed [TW-1:0] b_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_re;
    logic signed [OW-1:0] out_im;
`ifdef CMUL_SAT_FLAG_EN
    logic                 out_sat;
    logic [15:0]          sat_cnt;
`endif

    modport master (
        output in_valid, conj, a_re, a_im, b_re, b_im, out_ready,
        input  in_ready, out_valid, out_re, out_im
`ifdef CMUL_SAT_FLAG_EN
        , input out_sat, sat_cnt
`endif
    );

    modport slave (
        input  in_valid, conj, a_re, a_im, b_re, b_im, out_ready,
        output in_ready, out_valid, out_re, out_im
`ifdef CMUL_SAT_FLAG_EN
        , output out_sat, sat_cnt
`endif
    );
endinterface

// File: rtl/cmul_round_sat.sv
// cmul_round_sat: round (optional), arithmetic shift by TW-1 and clip one component to OW bits; sat_o with CMUL_SAT_FLAG_EN
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int SW    = 34,
    parameter int TW    = 16,
    parameter int OW    = 16,
    parameter int ROUND = 1
) (
    input  logic signed [SW-1:0] x_i,
    output logic signed [OW-1:0] y_o
`ifdef CMUL_SAT_FLAG_EN
    , output logic               sat_o
`endif
);
    localparam logic signed [SW-1:0] RC = (ROUND != 0) ? SW'(rnd_const(TW)) : '0;
    localparam logic signed [SW-1:0] HI = SW'(sat_hi(OW));
    localparam logic signed [SW-1:0] LO = SW'(sat_lo(OW));

    logic signed [SW-1:0] sh;
    logic                 hi;
    logic                 lo;

    // scale back to Q(OW) and clamp to the representable range
    always_comb begin
        sh  = (x_i + RC) >>> (TW - 1);
        hi  = sh > HI;
        lo  = sh < LO;
        y_o = hi ? HI[OW-1:0] : lo ? LO[OW-1:0] : sh[OW-1:0];
    end

`ifdef CMUL_SAT_FLAG_EN
    assign sat_o = hi | lo;
`endif
endmodule

// File: rtl/cmul_pipe.sv
// cmul_pipe: 3-stage stallable complex multiplier a*b or a*conj(b); CMUL_SAT_FLAG_EN adds out_sat/sat_cnt
module cmul_pipe
    import cmul_pkg::*;
#(
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int OW    = 16,
    parameter int ROUND = 1
) (
    input logic   clk,
    input logic   rst_n,
    cmul_if.slave bus
);
    localparam int PW = prod_w(DW, TW);
    localparam int SW = sum_w(DW, TW);

    logic                 adv;
    logic                 v1_q, v2_q, out_valid_q;
    logic signed [DW-1:0] a_re_q, a_im_q;
    logic signed [TW-1:0] b_re_q;
    logic signed [TW:0]   b_ext, b_im_d, b_im_q;
    logic signed [PW-1:0] pr_d, pi_d, qr_d, qi_d;
    logic signed [PW-1:0] pr_q, pi_q, qr_q, qi_q;
    logic signed [SW-1:0] re_d, im_d;
    logic signed [OW-1:0] out_re_d, out_im_d, out_re_q, out_im_q;

    assign adv           = !out_valid_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign b_ext         = (TW+1)'(bus.b_im);

    // conjugate in TW+1 bits so negating the most negative twiddle stays exact; products and sums at full precision
    always_comb begin
        b_im_d = bus.conj ? -b_ext : b_ext;
        pr_d   = PW'(a_re_q) * PW'(b_re_q);
        pi_d   = PW'(a_im_q) * PW'(b_im_q);
        qr_d   = PW'(a_re_q) * PW'(b_im_q);
        qi_d   = PW'(a_im_q) * PW'(b_re_q);
        re_d   = SW'(pr_q) - SW'(pi_q);
        im_d   = SW'(qr_q) + SW'(qi_q);
    end

`ifdef CMUL_SAT_FLAG_EN
    logic        sat_re, sat_im, out_sat_q;
    logic [15:0] sat_cnt_q;

    cmul_round_sat #(.SW(SW), .TW(TW), .OW(OW), .ROUND(ROUND)) u_re (.x_i(re_d), .y_o(out_re_d), .sat_o(sat_re));
    cmul_round_sat #(.SW(SW), .TW(TW), .OW(OW), .ROUND(ROUND)) u_im (.x_i(im_d), .y_o(out_im_d), .sat_o(sat_im));

    assign bus.out_sat = out_sat_q;
    assign bus.sat_cnt = sat_cnt_q;

    // sat flag travels with the result; counter bumps once per consumed saturated result and sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat_q <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (adv)
                out_sat_q <= v2_q & (sat_re | sat_im);
            if (out_valid_q & bus.out_ready & out_sat_q & ~&sat_cnt_q)
                sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end
`else
    cmul_round_sat #(.SW(SW), .TW(TW), .OW(OW), .ROUND(ROUND)) u_re (.x_i(re_d), .y_o(out_re_d));
    cmul_round_sat #(.SW(SW), .TW(TW), .OW(OW), .ROUND(ROUND)) u_im (.x_i(im_d), .y_o(out_im_d));
`endif

    // valid chain and result registers; everything holds while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else if (adv) begin
            v1_q        <= bus.in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    // operand and product registers carry no reset; their contents are qualified by the valid chain
    always_ff @(posedge clk) begin
        if (adv) begin
            a_re_q <= bus.a_re;
            a_im_q <= bus.a_im;
            b_re_q <= bus.b_re;
            b_im_q <= b_im_d;
            pr_q   <= pr_d;
            pi_q   <= pi_d;
            qr_q   <= qr_d;
            qi_q   <= qi_d;
        end
    end
endmodule

// File: tb/tb_cmul_pipe.sv
// tb_cmul_pipe: directed vectors for cmul_pipe, covering latency, conj, rounding, saturation, stall and reset (CMUL_SAT_FLAG_EN aware)
module tb_cmul_pipe;
    localparam int DW    = 16;
    localparam int TW    = 16;
    localparam int OW    = 16;
    localparam int ROUND = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   sent, rcvd, stall, cyc;
    logic seen;

    cmul_if #(.DW(DW), .TW(TW), .OW(OW)) bus ();

    cmul_pipe #(.DW(DW), .TW(TW), .OW(OW), .ROUND(ROUND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int are, input int aim, input int bre, input int bim, input logic cj, input logic v);
        bus.in_valid = v;
        bus.conj     = cj;
        bus.a_re     = DW'(are);
        bus.a_im     = DW'(aim);
        bus.b_re     = TW'(bre);
        bus.b_im     = TW'(bim);
    endtask

    task automatic run1(input string tag, input int are, input int aim, input int bre, input int bim,
                        input logic cj, input int ere, input int eim);
        int k;
        bus.out_ready = 1'b1;
        drive(are, aim, bre, bim, cj, 1'b1);
        step;
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        k = 1;
        while (!bus.out_valid && k < 10) begin
            step;
            k++;
        end
        check({tag, "_lat"}, k, 3);
        check({tag, "_re"}, bus.out_re, ere);
        check({tag, "_im"}, bus.out_im, eim);
    endtask

`ifdef CMUL_SAT_FLAG_EN
`define SAT_CHK(t, s, c) begin check({t, "_sat"}, bus.out_sat, s); step; check({t, "_cnt"}, bus.sat_cnt, c); end
`else
`define SAT_CHK(t, s, c) step
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_re", bus.out_re, 0);
        check("rst_im", bus.out_im, 0);
        check("rst_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        step;

        run1("unit", 16384, 0, 16384, 0, 1'b0, 8192, 0);
        `SAT_CHK("unit", 0, 0);
        run1("jj", 0, 16384, 0, 16384, 1'b0, -8192, 0);
        `SAT_CHK("jj", 0, 0);
        run1("jjc", 0, 16384, 0, 16384, 1'b1, 8192, 0);
        `SAT_CHK("jjc", 0, 0);
        run1("psat", -32768, 0, -32768, 0, 1'b0, 32767, 0);
        `SAT_CHK("psat", 1, 1);
        run1("nsat", -32768, -32768, 32767, -32768, 1'b0, -32768, 1);
        `SAT_CHK("nsat", 1, 2);
        run1("cjmin", -32768, 0, 0, -32768, 1'b1, 0, -32768);
        `SAT_CHK("cjmin", 0, 2);
        run1("rnd", 1, 0, 16384, 0, 1'b0, ROUND ? 1 : 0, 0);
        `SAT_CHK("rnd", 0, 2);
        run1("rndn", -1, 0, 16384, 0, 1'b0, ROUND ? 0 : -1, 0);
        `SAT_CHK("rndn", 0, 2);

        sent  = 0;
        rcvd  = 0;
        stall = 0;
        cyc   = 0;
        seen  = 1'b0;
        while (rcvd < 8 && cyc < 200) begin
            if (sent < 8)
                drive(200 * (sent + 1), -200 * (sent + 1), 16384, 0, 1'b0, 1'b1);
            else
                drive(0, 0, 0, 0, 1'b0, 1'b0);
            if (bus.out_valid && !seen) begin
                seen  = 1'b1;
                stall = 5;
            end
            bus.out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                check("stall_re", bus.out_re, 100 * (rcvd + 1));
                check("stall_im", bus.out_im, -100 * (rcvd + 1));
                check("stall_rdy", bus.in_ready, 0);
                check("stall_vld", bus.out_valid, 1);
                stall--;
            end else if (bus.out_valid) begin
                check("strm_re", bus.out_re, 100 * (rcvd + 1));
                check("strm_im", bus.out_im, -100 * (rcvd + 1));
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready)
                sent++;
            cyc++;
            step;
        end
        check("strm_cnt", rcvd, 8);
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (4) step;
        check("strm_dup", bus.out_valid, 0);

        for (int i = 0; i < 3; i++) begin
            drive(2000 * (i + 1), 0, 16384, 0, 1'b0, 1'b1);
            step;
        end
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        check("pre_rst_vld", bus.out_valid, 1);
        check("pre_rst_re", bus.out_re, 1000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", bus.out_valid, 0);
        check("mid_rst_re", bus.out_re, 0);
        check("mid_rst_im", bus.out_im, 0);
        step;
        rst_n = 1'b1;
        step;
        check("post_rst_vld", bus.out_valid, 0);
        run1("post", 16384, 0, 16384, 0, 1'b0, 8192, 0);
        `SAT_CHK("post", 0, 0);
        check("post_drain", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
